// File: rtl/int_sequencer_pkg.sv
// int_pkg: shared types and constants for the 6502 interrupt/reset entry
// sequencer (int_sequencer and nmi_edge_det).
//   int_type_t  - kind of entry being sequenced
//   seq_state_t - sequencer top-level state
//   vec_offset  - offset of a type's vector low byte from the NMI vector
package int_pkg;

  typedef enum logic [2:0] {
    INT_NONE,
    INT_RES,
    INT_NMI,
    INT_IRQ,
    INT_BRK
  } int_type_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_SEQ
  } seq_state_t;

  localparam logic [2:0] CYC_PUSH_H = 3'd2;  // first push cycle (PCH)
  localparam logic [2:0] CYC_PUSH_P = 3'd4;  // last push cycle (P)
  localparam logic [2:0] CYC_VEC_LO = 3'd5;
  localparam logic [2:0] CYC_VEC_HI = 3'd6;

  function automatic logic [15:0] vec_offset(input int_type_t t);
    case (t)
      INT_NMI:          return 16'd0;
      INT_RES:          return 16'd2;
      INT_IRQ, INT_BRK: return 16'd4;
      default:          return 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/int_sequencer_nmi_edge_det.sv
// nmi_edge_det: falling-edge detector and pending latch for the NMI line.
// Ports:
//   clk     - clock (rising edge)
//   n_rst   - synchronous active-low reset
//   n_nmip  - NMI from pad logic, active low
//   ack     - NMI committed this cycle; clears the pending latch
//   nmi_req - an NMI is requested (edge this cycle or latched earlier)
module nmi_edge_det (
  input  logic clk,
  input  logic n_rst,
  input  logic n_nmip,
  input  logic ack,
  output logic nmi_req
);

  logic nmi_prev;
  logic nmi_pend;
  logic nmi_edge;

  assign nmi_edge = nmi_prev & ~n_nmip;
  assign nmi_req  = nmi_edge | nmi_pend;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      nmi_prev <= 1'b1;
      nmi_pend <= 1'b0;
    end else begin
      nmi_prev <= n_nmip;
      // A new edge in the acknowledge cycle must not be lost: set wins.
      nmi_pend <= nmi_edge | (nmi_pend & ~ack);
    end
  end

endmodule

// File: rtl/int_sequencer.sv
// int_sequencer: arbitrates RES/NMI/IRQ/BRK and steps the 7-cycle 6502
// interrupt entry sequence (forced BRK opcode, dummy read, three pushes,
// vector low/high fetch).
// Ports:
//   PHI0, n_RES             - clock, synchronous active-low block reset
//   n_NMIP, n_IRQP, RESP    - pad-side interrupt/reset requests
//   I_FLAG, RDY, T1, BRK_DEC - CPU status / decoder inputs
//   FORCE_BRK, INT_ACTIVE, CYC, WR_SUPPRESS, B_FLAG, SET_I,
//   VEC_ADDR, VEC_VALID, NMI_ACK - sequence control outputs
// Build option: define INT_NMI_HIJACK_EN to let an NMI arriving up to the end
// of cycle 4 of an IRQ/BRK sequence take over its vector fetch.
module int_sequencer
  import int_pkg::*;
#(
  parameter logic [15:0] VEC_BASE = 16'hFFFA,
  parameter int          SEQ_LEN  = 7
) (
  input  logic        PHI0,
  input  logic        n_RES,
  input  logic        n_NMIP,
  input  logic        n_IRQP,
  input  logic        RESP,
  input  logic        I_FLAG,
  input  logic        RDY,
  input  logic        T1,
  input  logic        BRK_DEC,
  output logic        FORCE_BRK,
  output logic        INT_ACTIVE,
  output logic [2:0]  CYC,
  output logic        WR_SUPPRESS,
  output logic        B_FLAG,
  output logic        SET_I,
  output logic [15:0] VEC_ADDR,
  output logic        VEC_VALID,
  output logic        NMI_ACK
);

  localparam logic [2:0] CYC_LAST = 3'(SEQ_LEN - 1);

  seq_state_t state, state_nxt;
  logic [2:0] cyc, cyc_nxt;
  int_type_t  typ, typ_nxt;
  logic       res_pend, res_pend_nxt;
  logic       nmi_req;
  logic       irq_req;
  logic       push_cyc;
  logic       adv;
  logic       hijack;

  nmi_edge_det u_nmi (
    .clk     (PHI0),
    .n_rst   (n_RES),
    .n_nmip  (n_NMIP),
    .ack     (NMI_ACK),
    .nmi_req (nmi_req)
  );

  assign irq_req  = ~n_IRQP & ~I_FLAG;
  assign push_cyc = (cyc >= CYC_PUSH_H) && (cyc <= CYC_PUSH_P);
  // Push cycles are writes and ignore RDY; under reset they are reads and stall.
  assign adv      = RDY | (push_cyc & (typ != INT_RES));

`ifdef INT_NMI_HIJACK_EN
  assign hijack = ((typ == INT_IRQ) || (typ == INT_BRK)) && nmi_req;
`else
  assign hijack = 1'b0;
`endif

  always_ff @(posedge PHI0) begin
    if (!n_RES) begin
      state    <= S_IDLE;
      cyc      <= 3'd0;
      typ      <= INT_NONE;
      res_pend <= 1'b1;
    end else begin
      state    <= state_nxt;
      cyc      <= cyc_nxt;
      typ      <= typ_nxt;
      res_pend <= res_pend_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cyc_nxt      = cyc;
    typ_nxt      = typ;
    res_pend_nxt = res_pend;
    FORCE_BRK    = 1'b0;
    INT_ACTIVE   = 1'b0;
    CYC          = cyc;
    WR_SUPPRESS  = 1'b0;
    B_FLAG       = 1'b0;
    SET_I        = 1'b0;
    VEC_ADDR     = 16'h0000;
    VEC_VALID    = 1'b0;
    NMI_ACK      = 1'b0;

    case (state)
      S_IDLE: begin
        if (T1 && (res_pend || nmi_req || irq_req)) begin
          state_nxt = S_SEQ;
          cyc_nxt   = 3'd0;
          if (res_pend)     typ_nxt = INT_RES;
          else if (nmi_req) typ_nxt = INT_NMI;
          else              typ_nxt = INT_IRQ;
        end else if (BRK_DEC) begin
          // The BRK opcode was really fetched, so its cycle 0 is already done.
          state_nxt = S_SEQ;
          cyc_nxt   = 3'd1;
          typ_nxt   = INT_BRK;
        end
      end

      S_HOLD: begin
        if (!RESP) begin
          state_nxt = S_SEQ;
          cyc_nxt   = 3'd0;
          typ_nxt   = INT_RES;
        end
      end

      S_SEQ: begin
        INT_ACTIVE  = 1'b1;
        FORCE_BRK   = (cyc == 3'd0) && (typ != INT_BRK);
        WR_SUPPRESS = push_cyc && (typ == INT_RES);
        B_FLAG      = (cyc == CYC_PUSH_P) && (typ == INT_BRK);
        SET_I       = (cyc == CYC_VEC_LO);
        NMI_ACK     = (cyc == CYC_VEC_LO) && (typ == INT_NMI);
        if ((cyc == CYC_VEC_LO) || (cyc == CYC_VEC_HI)) begin
          VEC_VALID = 1'b1;
          VEC_ADDR  = VEC_BASE + vec_offset(typ) + {15'd0, cyc == CYC_VEC_HI};
        end
        if ((cyc == CYC_VEC_LO) && (typ == INT_RES)) res_pend_nxt = 1'b0;
        if (adv) begin
          if (cyc == CYC_LAST) begin
            state_nxt = S_IDLE;
            cyc_nxt   = 3'd0;
            typ_nxt   = INT_NONE;
          end else begin
            cyc_nxt = cyc + 3'd1;
            if ((cyc == CYC_PUSH_P) && hijack) typ_nxt = INT_NMI;
          end
        end
      end

      default: state_nxt = S_IDLE;
    endcase

    // Reset request overrides everything and aborts any sequence in flight.
    if (RESP) begin
      state_nxt    = S_HOLD;
      cyc_nxt      = 3'd0;
      typ_nxt      = INT_NONE;
      res_pend_nxt = 1'b1;
    end
  end

endmodule

// File: tb/tb_int_sequencer.sv
// tb_int_sequencer: directed self-checking bench for int_sequencer.
module tb_int_sequencer;

  logic        PHI0 = 1'b0;
  logic        n_RES, n_NMIP, n_IRQP, RESP, I_FLAG, RDY, T1, BRK_DEC;
  logic        FORCE_BRK, INT_ACTIVE, WR_SUPPRESS, B_FLAG, SET_I, VEC_VALID, NMI_ACK;
  logic [2:0]  CYC;
  logic [15:0] VEC_ADDR;

  int checks = 0;
  int errors = 0;

  always #5 PHI0 = ~PHI0;

  int_sequencer dut (
    .PHI0        (PHI0),
    .n_RES       (n_RES),
    .n_NMIP      (n_NMIP),
    .n_IRQP      (n_IRQP),
    .RESP        (RESP),
    .I_FLAG      (I_FLAG),
    .RDY         (RDY),
    .T1          (T1),
    .BRK_DEC     (BRK_DEC),
    .FORCE_BRK   (FORCE_BRK),
    .INT_ACTIVE  (INT_ACTIVE),
    .CYC         (CYC),
    .WR_SUPPRESS (WR_SUPPRESS),
    .B_FLAG      (B_FLAG),
    .SET_I       (SET_I),
    .VEC_ADDR    (VEC_ADDR),
    .VEC_VALID   (VEC_VALID),
    .NMI_ACK     (NMI_ACK)
  );

  // {INT_ACTIVE, CYC, FORCE_BRK, WR_SUPPRESS, B_FLAG, SET_I, VEC_VALID, NMI_ACK, VEC_ADDR}
  logic [25:0] obs;
  assign obs = {INT_ACTIVE, CYC, FORCE_BRK, WR_SUPPRESS, B_FLAG, SET_I,
                VEC_VALID, NMI_ACK, VEC_ADDR};

  localparam logic [25:0] IDLE = 26'h0;

  function automatic logic [25:0] ev(input logic [2:0] c, input logic fb, input logic wrs,
                                     input logic b, input logic si, input logic vv,
                                     input logic ack, input logic [15:0] va);
    return {1'b1, c, fb, wrs, b, si, vv, ack, va};
  endfunction

  task automatic tick;
    @(posedge PHI0);
    #1;
  endtask

  task automatic chk(input string tag, input logic [25:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    n_RES = 1'b0; n_NMIP = 1'b1; n_IRQP = 1'b1; RESP = 1'b0;
    I_FLAG = 1'b1; RDY = 1'b1; T1 = 1'b0; BRK_DEC = 1'b0;

    // Power-up reset, then the pending RES sequence at the first boundary
    tick; tick;
    chk("reset", IDLE);
    n_RES = 1'b1; T1 = 1'b1;
    tick; chk("res_c0", ev(3'd0, 1, 0, 0, 0, 0, 0, 16'h0000));
    T1 = 1'b0;
    tick; chk("res_c1", ev(3'd1, 0, 0, 0, 0, 0, 0, 16'h0000));
    tick; chk("res_c2", ev(3'd2, 0, 1, 0, 0, 0, 0, 16'h0000));
    tick; chk("res_c3", ev(3'd3, 0, 1, 0, 0, 0, 0, 16'h0000));
    tick; chk("res_c4", ev(3'd4, 0, 1, 0, 0, 0, 0, 16'h0000));
    tick; chk("res_c5", ev(3'd5, 0, 0, 0, 1, 1, 0, 16'hFFFC));
    tick; chk("res_c6", ev(3'd6, 0, 0, 0, 0, 1, 0, 16'hFFFD));
    tick; chk("res_done", IDLE);
    T1 = 1'b1;
    tick; chk("idle_nothing_pending", IDLE);
    T1 = 1'b0;

    // IRQ; request withdrawn right after entry still completes as IRQ
    I_FLAG = 1'b0; n_IRQP = 1'b0; T1 = 1'b1;
    tick; chk("irq_c0", ev(3'd0, 1, 0, 0, 0, 0, 0, 16'h0000));
    T1 = 1'b0; n_IRQP = 1'b1;
    tick; chk("irq_c1", ev(3'd1, 0, 0, 0, 0, 0, 0, 16'h0000));
    tick; chk("irq_c2", ev(3'd2, 0, 0, 0, 0, 0, 0, 16'h0000));
    tick; tick; chk("irq_c4", ev(3'd4, 0, 0, 0, 0, 0, 0, 16'h0000));
    tick; chk("irq_c5", ev(3'd5, 0, 0, 0, 1, 1, 0, 16'hFFFE));
    tick; chk("irq_c6", ev(3'd6, 0, 0, 0, 0, 1, 0, 16'hFFFF));
    tick; chk("irq_done", IDLE);
    I_FLAG = 1'b1; n_IRQP = 1'b0; T1 = 1'b1;
    tick; chk("irq_masked", IDLE);
    n_IRQP = 1'b1; T1 = 1'b0;

    // NMI edge, line held low across two boundaries
    n_NMIP = 1'b0;
    tick; chk("nmi_latched_idle", IDLE);
    T1 = 1'b1;
    tick; chk("nmi_c0", ev(3'd0, 1, 0, 0, 0, 0, 0, 16'h0000));
    T1 = 1'b0;
    tick; tick; tick; tick;
    chk("nmi_c4", ev(3'd4, 0, 0, 0, 0, 0, 0, 16'h0000));
    tick; chk("nmi_c5", ev(3'd5, 0, 0, 0, 1, 1, 1, 16'hFFFA));
    tick; chk("nmi_c6", ev(3'd6, 0, 0, 0, 0, 1, 0, 16'hFFFB));
    tick; chk("nmi_done", IDLE);
    T1 = 1'b1;
    tick; chk("nmi_no_repeat", IDLE);
    T1 = 1'b0; n_NMIP = 1'b1;
    tick;

    // Software BRK with an NMI edge arriving in cycle 3
    BRK_DEC = 1'b1;
    tick; chk("brk_c1", ev(3'd1, 0, 0, 0, 0, 0, 0, 16'h0000));
    BRK_DEC = 1'b0;
    tick; tick; chk("brk_c3", ev(3'd3, 0, 0, 0, 0, 0, 0, 16'h0000));
    n_NMIP = 1'b0;
    tick; chk("brk_c4", ev(3'd4, 0, 0, 1, 0, 0, 0, 16'h0000));
`ifdef INT_NMI_HIJACK_EN
    tick; chk("brk_hijack_c5", ev(3'd5, 0, 0, 0, 1, 1, 1, 16'hFFFA));
    tick; chk("brk_hijack_c6", ev(3'd6, 0, 0, 0, 0, 1, 0, 16'hFFFB));
    tick; chk("brk_done", IDLE);
    T1 = 1'b1;
    tick; chk("brk_nmi_consumed", IDLE);
    T1 = 1'b0;
`else
    tick; chk("brk_c5", ev(3'd5, 0, 0, 0, 1, 1, 0, 16'hFFFE));
    tick; chk("brk_c6", ev(3'd6, 0, 0, 0, 0, 1, 0, 16'hFFFF));
    tick; chk("brk_done", IDLE);
    T1 = 1'b1;
    tick; chk("late_nmi_c0", ev(3'd0, 1, 0, 0, 0, 0, 0, 16'h0000));
    T1 = 1'b0;
    tick; tick; tick; tick; tick;
    chk("late_nmi_c5", ev(3'd5, 0, 0, 0, 1, 1, 1, 16'hFFFA));
    tick; tick; chk("late_nmi_done", IDLE);
`endif
    n_NMIP = 1'b1;
    tick;

    // RDY low through IRQ push cycles: sequence keeps advancing
    I_FLAG = 1'b0; n_IRQP = 1'b0; T1 = 1'b1;
    tick; T1 = 1'b0; n_IRQP = 1'b1;
    tick; tick; chk("rdy_irq_c2", ev(3'd2, 0, 0, 0, 0, 0, 0, 16'h0000));
    RDY = 1'b0;
    tick; chk("rdy_irq_c3", ev(3'd3, 0, 0, 0, 0, 0, 0, 16'h0000));
    tick; chk("rdy_irq_c4", ev(3'd4, 0, 0, 0, 0, 0, 0, 16'h0000));
    tick; chk("rdy_irq_c5", ev(3'd5, 0, 0, 0, 1, 1, 0, 16'hFFFE));
    tick; chk("rdy_irq_c5_held", ev(3'd5, 0, 0, 0, 1, 1, 0, 16'hFFFE));
    RDY = 1'b1;
    tick; chk("rdy_irq_c6", ev(3'd6, 0, 0, 0, 0, 1, 0, 16'hFFFF));
    tick; chk("rdy_irq_done", IDLE);
    I_FLAG = 1'b1;

    // RDY low in RES push cycle 2: sequence stalls
    RESP = 1'b1;
    tick; chk("hold", IDLE);
    RESP = 1'b0;
    tick; chk("rdy_res_c0", ev(3'd0, 1, 0, 0, 0, 0, 0, 16'h0000));
    tick; tick; chk("rdy_res_c2", ev(3'd2, 0, 1, 0, 0, 0, 0, 16'h0000));
    RDY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick; chk("rdy_res_c2_held", ev(3'd2, 0, 1, 0, 0, 0, 0, 16'h0000));
    end
    RDY = 1'b1;
    tick; chk("rdy_res_c3", ev(3'd3, 0, 1, 0, 0, 0, 0, 16'h0000));
    tick; tick; chk("rdy_res_c5", ev(3'd5, 0, 0, 0, 1, 1, 0, 16'hFFFC));
    tick; tick; chk("rdy_res_done", IDLE);

    // Reset request aborts an NMI sequence; the NMI is still serviced after
    n_NMIP = 1'b0;
    tick; T1 = 1'b1;
    tick; T1 = 1'b0;
    tick; tick; tick; chk("abort_nmi_c3", ev(3'd3, 0, 0, 0, 0, 0, 0, 16'h0000));
    RESP = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick; chk("abort_hold", IDLE);
    end
    RESP = 1'b0;
    tick; chk("abort_res_c0", ev(3'd0, 1, 0, 0, 0, 0, 0, 16'h0000));
    tick; tick; tick; tick; tick;
    chk("abort_res_c5", ev(3'd5, 0, 0, 0, 1, 1, 0, 16'hFFFC));
    tick; chk("abort_res_c6", ev(3'd6, 0, 0, 0, 0, 1, 0, 16'hFFFD));
    tick; chk("abort_res_done", IDLE);
    T1 = 1'b1;
    tick; chk("abort_nmi_again_c0", ev(3'd0, 1, 0, 0, 0, 0, 0, 16'h0000));
    T1 = 1'b0;
    tick; tick; tick; tick; tick;
    chk("abort_nmi_again_c5", ev(3'd5, 0, 0, 0, 1, 1, 1, 16'hFFFA));
    tick; tick; chk("abort_nmi_again_done", IDLE);
    n_NMIP = 1'b1;
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_sequencer.md
Name: int_sequencer

Overview:
- Sequences the 6502 interrupt and reset entry.
- Consumes the pad-side interrupt outputs n_NMIP, n_IRQP and RESP.
- Arbitrates between RES, NMI, IRQ and software BRK, then steps a 7-cycle entry sequence that forces the BRK opcode, suppresses writes during reset, and selects the vector address.
- Sits between the pad logic and the decoder/address-bus control.

Parameters:
- VEC_BASE, 16'hFFFA, address of the NMI vector low byte; RES = base+2, IRQ/BRK = base+4.
- SEQ_LEN, 7, number of entry-sequence cycles (0..6); the counter is 3 bits.

Ports:
- PHI0  in  1  single clock; all state updates on the rising edge.
- n_RES  in  1  synchronous, active-low block reset.
- n_NMIP  in  1  NMI from pad logic, active low.
- n_IRQP  in  1  IRQ from pad logic, active low, level.
- RESP  in  1  reset request from pad logic, active high.
- I_FLAG  in  1  interrupt-disable flag.
- RDY  in  1  ready; 0 stalls read cycles.
- T1  in  1  instruction boundary; the next cycle is an opcode fetch.
- BRK_DEC  in  1  decoder has fetched opcode 0x00 (software BRK), valid in the opcode-fetch cycle.
- FORCE_BRK  out  1  replace the fetched opcode with 0x00.
- INT_ACTIVE  out  1  entry sequence in progress.
- CYC  out  3  current sequence cycle.
- WR_SUPPRESS  out  1  turn push writes into reads (reset only).
- B_FLAG  out  1  value of B in the pushed P (1 only for software BRK).
- SET_I  out  1  one-cycle strobe to set I.
- VEC_ADDR  out  16  vector fetch address.
- VEC_VALID  out  1  VEC_ADDR drives the address bus.
- NMI_ACK  out  1  one-cycle strobe when NMI is committed.

Behaviour:
- Block reset (n_RES=0 at the clock edge):
  - State goes to IDLE; CYC=0.
  - All outputs are 0 and VEC_ADDR=0.
  - nmi_prev=1, nmi_pend=0.
  - res_pend=1, so the first boundary after reset runs a RES sequence.
- NMI edge detection:
  - Edge = nmi_prev & ~n_NMIP; nmi_prev updates every cycle.
  - An edge sets nmi_pend.
  - nmi_pend clears on the NMI_ACK cycle; an edge in that same cycle leaves nmi_pend set (set wins).
- IRQ is level-sampled, never latched; an IRQ request is ~n_IRQP & ~I_FLAG.
- States:
  - IDLE: waits for a boundary.
  - HOLD: RESP=1.
  - SEQ: counter 0..6.
- Transitions:
  - RESP=1 in any state → HOLD next cycle; an in-flight sequence is aborted and res_pend=1.
  - HOLD → SEQ cycle 0 with type RES on the cycle RESP falls.
  - IDLE with T1=1: select the highest pending of RES > NMI > IRQ and go to SEQ cycle 0 with that type.
  - IDLE with T1=1 and nothing pending: stay in IDLE.
  - BRK_DEC=1 in IDLE (and no forced entry) → SEQ cycle 1 with type BRK.
- Cycles 0-4:
  - Cycle 0: FORCE_BRK=1 (hardware types only).
  - Cycle 1: dummy read.
  - Cycles 2, 3, 4: push PCH, PCL, P.
  - WR_SUPPRESS=1 in cycles 2-4 for type RES only.
  - B_FLAG=1 in cycle 4 for type BRK only.
- Cycles 5-6:
  - Type is committed at the end of cycle 4.
  - Cycle 5: VEC_VALID=1, VEC_ADDR = vector low.
  - Cycle 6: VEC_VALID=1, VEC_ADDR = vector low + 1.
  - SET_I=1 in cycle 5.
  - NMI_ACK=1 in cycle 5 when the committed type is NMI.
  - res_pend clears in cycle 5 of a RES sequence.
  - After cycle 6: IDLE.
- RDY stall:
  - RDY=0 holds CYC and all outputs in cycles 0, 1, 5, 6.
  - Cycles 2-4 ignore RDY (writes), except for type RES, where they are reads and do stall.
- Simultaneous events:
  - RESP and NMI edge in the same cycle: RES wins; nmi_pend is retained.
  - IRQ deasserted after sequence entry: the sequence completes as IRQ.

Optional Feature:
- Macro: INT_NMI_HIJACK_EN.
- Defined: an NMI edge or nmi_pend present at or before the end of cycle 4 of an IRQ or BRK sequence changes the committed type to NMI. VEC_ADDR then uses the NMI vector and NMI_ACK fires in cycle 5. B_FLAG stays as already pushed.
- Undefined: the type is fixed at sequence entry; a late NMI is serviced at the next boundary.

Decomposition:
- Package int_pkg holds:
  - enum int_type_t {INT_NONE, INT_RES, INT_NMI, INT_IRQ, INT_BRK};
  - enum seq_state_t {S_IDLE, S_HOLD, S_SEQ};
  - localparams CYC_PUSH_P=4, CYC_VEC_LO=5, CYC_VEC_HI=6;
  - function vec_offset(int_type_t).
- One sub-module: nmi_edge_det, containing nmi_prev, the edge logic and the set-dominant nmi_pend register.

Test Plan:
- Power-up: n_RES low for 2 cycles, then high; T1=1 → cycles 0-6 run with WR_SUPPRESS=1 in cycles 2-4, then VEC_ADDR=FFFC, FFFD with VEC_VALID=1.
- IRQ: n_IRQP=0, I_FLAG=0, T1 pulse → FORCE_BRK in cycle 0, B_FLAG=0 in cycle 4, VEC_ADDR=FFFE/FFFF, SET_I in cycle 5. Repeat with I_FLAG=1 → stays IDLE.
- NMI edge: n_NMIP 1→0 held low across two boundaries → exactly one NMI sequence, VEC_ADDR=FFFA/FFFB, one NMI_ACK pulse.
- Hijack: BRK_DEC=1, then n_NMIP falls in cycle 3 → with the macro, VEC_ADDR=FFFA, B_FLAG=1, NMI_ACK=1; without it, VEC_ADDR=FFFE and NMI runs at the next boundary.
- RDY: RDY=0 for 3 cycles in cycle 2 of IRQ → CYC advances; the same in a RES sequence → CYC held at 2 for 3 cycles.
- Abort: RESP=1 in cycle 3 of NMI, released 4 cycles later → HOLD, then a RES sequence; nmi_pend still set, so NMI follows at the next T1.
